// File: rtl/udp_mii_tx.sv
// Fixed-length UDP/IPv4/Ethernet frame transmitter on a 4-bit MII, one nibble per s_clk.
// Define UDP_TX_IPCSUM_EN to compute the IPv4 header checksum; otherwise the field is sent as zero.
module udp_mii_tx #(
  parameter logic [47:0] SRC_MAC       = 48'h00_0A_35_01_02_03,
  parameter logic [31:0] SRC_IP        = 32'hC0A8_0002,
  parameter logic [15:0] SRC_PORT      = 16'd8080,
  parameter logic [15:0] DST_PORT      = 16'd8080,
  parameter int unsigned PAYLOAD_BYTES = 64
) (
  input  logic        s_clk,
  input  logic        rst,
  input  logic        go,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  input  logic [3:0]  fifo_data,
  output logic        fifo_en,
  output logic [3:0]  tx_data,
  output logic        tx_en,
  output logic        busy
);

  localparam int unsigned CNT_W    = 12;
  localparam int unsigned PAY_NIB  = 2 * PAYLOAD_BYTES;
  localparam int unsigned PRE_LAST = 15;
  localparam int unsigned HDR_LAST = 83;
  localparam int unsigned FCS_LAST = 7;
  localparam int unsigned IFG_LAST = 24;
  localparam logic [15:0] IP_LEN   = 16'(28 + PAYLOAD_BYTES);
  localparam logic [15:0] UDP_LEN  = 16'(8 + PAYLOAD_BYTES);
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, IFG} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [47:0]      dst_mac_q, dst_mac_nx;
  logic [31:0]      dst_ip_q, dst_ip_nx;
  logic [15:0]      ident, ident_nx;
  logic [31:0]      crc, crc_nx;
  logic [31:0]      fcs;
  logic [3:0]       tx_data_nx;
  logic             tx_en_nx;
  logic             fifo_en_nx;
  logic [15:0]      ip_csum;
  logic [335:0]     hdr;
  logic [5:0]       hdr_idx;
  logic [8:0]       hdr_sh;
  logic [7:0]       hdr_byte;
  logic [3:0]       hdr_nib;

  // Reflected CRC-32 advanced by one nibble, LSB first
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

`ifdef UDP_TX_IPCSUM_EN
  logic [15:0] csum_acc, csum_acc_nx, csum_word;
  logic [16:0] csum_sum;

  // One header word per preamble cycle, end-around carry folded each step
  always_comb begin
    csum_word = 16'h0000;
    case (cnt[3:0])
      4'd1:    csum_word = 16'h4500;
      4'd2:    csum_word = IP_LEN;
      4'd3:    csum_word = ident;
      4'd4:    csum_word = 16'h4000;
      4'd5:    csum_word = 16'h4011;
      4'd6:    csum_word = SRC_IP[31:16];
      4'd7:    csum_word = SRC_IP[15:0];
      4'd8:    csum_word = dst_ip_q[31:16];
      4'd9:    csum_word = dst_ip_q[15:0];
      default: csum_word = 16'h0000;
    endcase
    csum_sum    = {1'b0, csum_acc} + {1'b0, csum_word};
    csum_acc_nx = csum_acc;
    if (state == IDLE) begin
      csum_acc_nx = 16'h0000;
    end else if (state == PREAMBLE) begin
      csum_acc_nx = csum_sum[15:0] + 16'(csum_sum[16]);
    end
  end

  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      csum_acc <= 16'h0000;
    end else begin
      csum_acc <= csum_acc_nx;
    end
  end

  assign ip_csum = ~csum_acc;
`else
  assign ip_csum = 16'h0000;
`endif

  assign fcs = ~crc;

  assign hdr = {dst_mac_q, SRC_MAC, 16'h0800,
                8'h45, 8'h00, IP_LEN, ident, 16'h4000, 8'h40, 8'h11, ip_csum,
                SRC_IP, dst_ip_q,
                SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

  // Header byte 0 sits in the top bits; low nibble of each byte goes first
  always_comb begin
    hdr_idx  = cnt[6:1];
    hdr_sh   = {6'd41 - hdr_idx, 3'b000};
    hdr_byte = 8'(hdr >> hdr_sh);
    hdr_nib  = cnt[0] ? hdr_byte[7:4] : hdr_byte[3:0];
  end

  // Next state; tx_* next values are the nibble prepared in the current state
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CNT_W'(1);
    tx_en_nx   = 1'b0;
    tx_data_nx = 4'h0;
    crc_nx     = crc;
    ident_nx   = ident;
    dst_mac_nx = dst_mac_q;
    dst_ip_nx  = dst_ip_q;
    fifo_en_nx = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        crc_nx = 32'hFFFF_FFFF;
        if (go) begin
          state_nx   = PREAMBLE;
          cnt_nx     = CNT_W'(1);
          tx_en_nx   = 1'b1;
          tx_data_nx = 4'h5;
          dst_mac_nx = dst_mac;
          dst_ip_nx  = dst_ip;
        end
      end
      PREAMBLE: begin
        tx_en_nx   = 1'b1;
        tx_data_nx = (cnt == CNT_W'(PRE_LAST)) ? 4'hD : 4'h5;
        if (cnt == CNT_W'(PRE_LAST)) begin
          state_nx = HEADER;
          cnt_nx   = '0;
        end
      end
      HEADER: begin
        tx_en_nx   = 1'b1;
        tx_data_nx = hdr_nib;
        crc_nx     = crc_nib(crc, hdr_nib);
        if (cnt == CNT_W'(HDR_LAST)) begin
          state_nx = PAYLOAD;
          cnt_nx   = '0;
        end
      end
      PAYLOAD: begin
        tx_en_nx   = 1'b1;
        tx_data_nx = fifo_data;
        crc_nx     = crc_nib(crc, fifo_data);
        if (cnt == CNT_W'(PAY_NIB - 1)) begin
          state_nx = FCS;
          cnt_nx   = '0;
        end
      end
      FCS: begin
        tx_en_nx   = 1'b1;
        tx_data_nx = 4'(fcs >> {cnt[2:0], 2'b00});
        if (cnt == CNT_W'(FCS_LAST)) begin
          state_nx = IFG;
          cnt_nx   = '0;
          ident_nx = ident + 16'd1;
        end
      end
      IFG: begin
        if (cnt == CNT_W'(IFG_LAST)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    // Strobe one cycle ahead of the payload slot that consumes the nibble
    if (state_nx == HEADER && cnt_nx == CNT_W'(HDR_LAST)) begin
      fifo_en_nx = 1'b1;
    end else if (state_nx == PAYLOAD && cnt_nx != CNT_W'(PAY_NIB - 1)) begin
      fifo_en_nx = 1'b1;
    end
  end

  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_en     <= 1'b0;
      tx_data   <= 4'h0;
      fifo_en   <= 1'b0;
      busy      <= 1'b0;
      ident     <= 16'h0000;
      crc       <= 32'hFFFF_FFFF;
      dst_mac_q <= '0;
      dst_ip_q  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      tx_en     <= tx_en_nx;
      tx_data   <= tx_data_nx;
      fifo_en   <= fifo_en_nx;
      busy      <= (state_nx != IDLE);
      ident     <= ident_nx;
      crc       <= crc_nx;
      dst_mac_q <= dst_mac_nx;
      dst_ip_q  <= dst_ip_nx;
    end
  end

endmodule
